// File: rtl/spi_cmd_sequencer.sv
// Command front-end for the SPI memory top: buffers host commands in a FIFO, issues them
// downstream one at a time and returns one response per command, timing out stuck ones.
module spi_cmd_sequencer #(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_wr,
   input  logic [AW-1:0]              cmd_addr,
   input  logic [DW-1:0]              cmd_din,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic                       rsp_wr,
   output logic [AW-1:0]              rsp_addr,
   output logic [DW-1:0]              rsp_data,
   output logic                       rsp_err,
   output logic                       rsp_tmo,
   output logic                       m_req,
   output logic                       m_wr,
   output logic [AW-1:0]              m_addr,
   output logic [DW-1:0]              m_din,
   input  logic [DW-1:0]              m_dout,
   input  logic                       m_done,
   input  logic                       m_err,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic [7:0]                 err_cnt
);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT);

   localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
   localparam logic [LW-1:0] LVL_ONE   = LW'(1'b1);
   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
   localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t          state_r;
   logic            fifo_wr_r   [DEPTH];
   logic [AW-1:0]   fifo_addr_r [DEPTH];
   logic [DW-1:0]   fifo_din_r  [DEPTH];
   logic [PW-1:0]   wptr_r;
   logic [PW-1:0]   rptr_r;
   logic [LW-1:0]   level_r;
   logic [LW-1:0]   level_nxt_s;
   logic            ready_r;
   logic            push_s;
   logic            pop_s;
   logic [CW-1:0]   tmo_cnt_r;
   logic            iss_wr_r;
   logic [AW-1:0]   iss_addr_r;
   logic [DW-1:0]   iss_din_r;
   logic            req_r;
   logic            rsp_valid_r;
   logic [DW-1:0]   rsp_data_r;
   logic            rsp_err_r;
   logic            rsp_tmo_r;
   logic [7:0]      err_cnt_r;

   // Push/pop decode and next FIFO occupancy.
   always_comb begin
      push_s      = cmd_valid & ready_r;
      pop_s       = 1'b0;
      level_nxt_s = level_r;
      if ((state_r == ST_IDLE) && (level_r != LVL_ZERO)) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
      if (push_s && !pop_s) begin
         level_nxt_s = level_r + LVL_ONE;
      end else if (pop_s && !push_s) begin
         level_nxt_s = level_r - LVL_ONE;
      end else begin
         level_nxt_s = level_r;
      end
   end

   // FIFO storage; ready_r is low in reset so nothing is written then.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_wr_r[wptr_r]   <= cmd_wr;
         fifo_addr_r[wptr_r] <= cmd_addr;
         fifo_din_r[wptr_r]  <= cmd_din;
      end
   end

   // FIFO pointers, occupancy and the registered accept flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_r  <= {PW{1'b0}};
         rptr_r  <= {PW{1'b0}};
         level_r <= LVL_ZERO;
         ready_r <= 1'b0;
      end else begin
         if (push_s) begin
            wptr_r <= wptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rptr_r <= rptr_r + PTR_ONE;
         end
         level_r <= level_nxt_s;
         ready_r <= (level_nxt_s != LVL_FULL);
      end
   end

   // Issue FSM: pop, present downstream, wait or time out, then hold the response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         tmo_cnt_r   <= CNT_ZERO;
         iss_wr_r    <= 1'b0;
         iss_addr_r  <= {AW{1'b0}};
         iss_din_r   <= DATA_ZERO;
         req_r       <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= DATA_ZERO;
         rsp_err_r   <= 1'b0;
         rsp_tmo_r   <= 1'b0;
         err_cnt_r   <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  iss_wr_r   <= fifo_wr_r[rptr_r];
                  iss_addr_r <= fifo_addr_r[rptr_r];
                  iss_din_r  <= fifo_din_r[rptr_r];
                  state_r    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               tmo_cnt_r <= CNT_ZERO;
               req_r     <= 1'b1;
               state_r   <= ST_WAIT;
            end
            ST_WAIT: begin
               // A completion in the last counted cycle takes priority over the timeout.
               if (m_done) begin
                  rsp_data_r  <= iss_wr_r ? DATA_ZERO : m_dout;
                  rsp_err_r   <= m_err;
                  rsp_tmo_r   <= 1'b0;
                  req_r       <= 1'b0;
                  rsp_valid_r <= 1'b1;
                  state_r     <= ST_RESP;
               end else if (tmo_cnt_r == CNT_LAST) begin
                  rsp_data_r  <= DATA_ZERO;
                  rsp_err_r   <= 1'b1;
                  rsp_tmo_r   <= 1'b1;
                  req_r       <= 1'b0;
                  rsp_valid_r <= 1'b1;
                  state_r     <= ST_RESP;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  if (rsp_err_r && (err_cnt_r != 8'hFF)) begin
                     err_cnt_r <= err_cnt_r + 8'd1;
                  end
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               req_r       <= 1'b0;
               rsp_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready = ready_r;
   assign level     = level_r;
   assign err_cnt   = err_cnt_r;
   assign m_req     = req_r;
   assign m_wr      = iss_wr_r;
   assign m_addr    = iss_addr_r;
   assign m_din     = iss_din_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_wr    = iss_wr_r;
   assign rsp_addr  = iss_addr_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_err   = rsp_err_r;
   assign rsp_tmo   = rsp_tmo_r;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: a behavioural downstream memory, an in-order
// reference model for responses, and a monitor comparing every response handshake.
module tb_spi_cmd_sequencer;
   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_wr;
   logic [7:0] cmd_addr, cmd_din;
   logic       rsp_valid, rsp_ready, rsp_wr, rsp_err, rsp_tmo;
   logic [7:0] rsp_addr, rsp_data;
   logic       m_req, m_wr, m_done, m_err;
   logic [7:0] m_addr, m_din, m_dout;
   logic [2:0] level;
   logic [7:0] err_cnt;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] din;
      int         lat;   // cycles of m_req before m_done; -1 = never completes
      logic       merr;
   } cmd_t;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic       err;
      logic       tmo;
   } rsp_t;

   cmd_t       iss_q[$];
   rsp_t       exp_q[$];
   logic [7:0] mmem [256] = '{default: 8'h00};
   logic [7:0] dmem [256] = '{default: 8'h00};
   int         vectors     = 0;
   int         miscompares = 0;
   bit         rr_rand     = 1'b0;
   logic       rr_val      = 1'b1;

   always #5 clk = ~clk;

   spi_cmd_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_din(cmd_din),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
      .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
      .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_din(m_din),
      .m_dout(m_dout), .m_done(m_done), .m_err(m_err),
      .level(level), .err_cnt(err_cnt)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: executes commands in acceptance order against its own memory.
   task automatic accept(input cmd_t c);
      rsp_t e;
      bit   never;
      never  = (c.lat < 0);
      e.wr   = c.wr;
      e.addr = c.addr;
      e.data = (c.wr || never) ? 8'h00 : mmem[c.addr];
      e.err  = never ? 1'b1 : c.merr;
      e.tmo  = never;
      if (c.wr && !never) mmem[c.addr] = c.din;
      exp_q.push_back(e);
      iss_q.push_back(c);
   endtask

   task automatic send(input logic wr, input logic [7:0] addr, input logic [7:0] din,
                       input int lat, input logic merr);
      int   n = 0;
      cmd_t c;
      c.wr = wr; c.addr = addr; c.din = din; c.lat = lat; c.merr = merr;
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_din = din;
      while (!cmd_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("push_accept", 64'(cmd_ready), 64'd1);
      else accept(c);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || rsp_valid || m_req) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
   endtask

   task automatic chk_rst_outputs(input string name);
      chk(name, {14'd0, cmd_ready, rsp_valid, rsp_wr, rsp_addr, rsp_data, rsp_err, rsp_tmo,
                 m_req, m_wr, m_addr, m_din, level, err_cnt}, 64'd0);
   endtask

   initial begin : rsp_ready_drv
      rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         rsp_ready = rr_rand ? ($urandom_range(3) != 0) : rr_val;
      end
   end

   // Downstream memory: answers each m_req after its planned latency.
   initial begin : responder
      cmd_t cur;
      bit   active = 1'b0;
      int   cnt = 0;
      m_done = 1'b0; m_err = 1'b0; m_dout = 8'h00;
      cur.wr = 1'b0; cur.addr = 8'h00; cur.din = 8'h00; cur.lat = -1; cur.merr = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            active = 1'b0; m_done = 1'b0; m_err = 1'b0;
         end else if (m_req) begin
            if (!active) begin
               if (iss_q.size() == 0) begin
                  chk("issue_unexpected", 64'd1, 64'd0);
                  cur.lat = -1;
               end else begin
                  cur = iss_q.pop_front();
               end
               active = 1'b1;
               cnt = 0;
            end
            cnt++;
            chk("m_fields", 64'({m_wr, m_addr, m_din}), 64'({cur.wr, cur.addr, cur.din}));
            if (cur.lat >= 0 && cnt == cur.lat + 1) begin
               m_done = 1'b1;
               m_err  = cur.merr;
               m_dout = cur.wr ? 8'($urandom) : dmem[cur.addr];
               if (cur.wr) dmem[cur.addr] = cur.din;
            end else begin
               m_done = 1'b0; m_err = 1'($urandom); m_dout = 8'($urandom);
            end
         end else begin
            if (active) begin
               chk("req_cycles", 64'(cnt), 64'((cur.lat < 0) ? 256 : cur.lat + 1));
               active = 1'b0;
            end
            m_done = ($urandom_range(7) == 0);
            m_err  = 1'($urandom);
            m_dout = 8'($urandom);
         end
      end
   end

   // Monitor: scoreboard pop on each response handshake plus per-cycle invariants.
   initial begin : monitor
      rsp_t        e;
      bit          pend = 1'b0;
      logic [18:0] prev = 19'd0;
      int          exp_err = 0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            pend = 1'b0;
            exp_err = 0;
         end else begin
            chk("err_cnt", 64'(err_cnt), 64'(exp_err));
            chk("cmd_ready_vs_level", 64'(cmd_ready), 64'(level != 3'd4));
            if (pend)
               chk("rsp_frozen", 64'({rsp_valid, rsp_wr, rsp_addr, rsp_data, rsp_err, rsp_tmo}),
                   64'({1'b1, prev}));
            if (rsp_valid) chk("m_req_in_resp", 64'(m_req), 64'd0);
            pend = rsp_valid && !rsp_ready;
            prev = {rsp_wr, rsp_addr, rsp_data, rsp_err, rsp_tmo};
            if (rsp_valid && rsp_ready) begin
               if (exp_q.size() == 0) begin
                  chk("rsp_unexpected", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp", 64'({rsp_wr, rsp_addr, rsp_data, rsp_err, rsp_tmo}),
                      64'({e.wr, e.addr, e.data, e.err, e.tmo}));
                  if (e.err && exp_err < 255) exp_err++;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      rst = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_din = 8'h00;
      repeat (3) @(negedge clk);
      chk_rst_outputs("reset_outputs");
      #3 rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 64'(cmd_ready), 64'd1);

      // Single write, issue latency, then read-back.
      send(1'b1, 8'h10, 8'hA5, 20, 1'b0);
      chk("level_after_push", 64'(level), 64'd1);
      chk("m_req_push_edge", 64'(m_req), 64'd0);
      @(negedge clk);
      chk("m_req_plus1", 64'(m_req), 64'd0);
      @(negedge clk);
      chk("m_req_plus2", 64'(m_req), 64'd1);
      send(1'b0, 8'h10, 8'h00, 5, 1'b0);
      drain(300);

      // Timeout, normal write, and m_done in the final counted cycle.
      send(1'b0, 8'h33, 8'h00, -1, 1'b0);
      send(1'b1, 8'h34, 8'h11, 3, 1'b0);
      send(1'b0, 8'h34, 8'h00, 255, 1'b1);
      drain(1500);
      chk("err_cnt_after_tmo", 64'(err_cnt), 64'd2);

      // Fill the FIFO behind a stalled downstream.
      for (int i = 0; i < 5; i++) send(1'(i), 8'(8'h40 + i), 8'(i * 3), 100, 1'b0);
      chk("level_full", 64'(level), 64'd4);
      chk("ready_full", 64'(cmd_ready), 64'd0);
      send(1'b0, 8'h41, 8'h00, 2, 1'b0);
      drain(2000);

      // Response back-pressure with three commands queued.
      rr_val = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) send(1'b0, 8'(8'h40 + i), 8'h00, 2, 1'b0);
      repeat (50) @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_level", 64'(level), 64'd3);
      chk("bp_m_req", 64'(m_req), 64'd0);
      rr_val = 1'b1;
      drain(300);

      // Randomised traffic.
      rr_rand = 1'b1;
      for (int i = 0; i < 150; i++) begin
         int r, lat;
         r   = $urandom_range(39);
         lat = (r == 0) ? -1 : (r == 1) ? 255 : int'($urandom_range(12));
         send(1'($urandom), 8'($urandom_range(15)), 8'($urandom), lat, ($urandom_range(5) == 0));
         repeat ($urandom_range(2)) @(negedge clk);
      end
      rr_rand = 1'b0;
      rr_val  = 1'b1;
      drain(6000);

      // Error counter saturation.
      for (int i = 0; i < 260; i++) send(1'b1, 8'($urandom), 8'($urandom), 0, 1'b1);
      drain(3000);
      chk("err_cnt_sat", 64'(err_cnt), 64'd255);

      // Reset while waiting downstream with two commands queued.
      for (int i = 0; i < 3; i++) send(1'b0, 8'(8'h20 + i), 8'h00, -1, 1'b0);
      n = 0;
      while (!m_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("reach_wait", 64'(m_req), 64'd1);
      repeat (5) @(negedge clk);
      chk("level_pre_rst", 64'(level), 64'd2);
      #2 rst = 1'b0;
      #1 chk_rst_outputs("mid_reset_outputs");
      exp_q.delete();
      iss_q.delete();
      repeat (3) @(negedge clk);
      #3 rst = 1'b1;
      @(negedge clk);
      chk("ready_after_mid_rst", 64'(cmd_ready), 64'd1);
      chk("level_after_mid_rst", 64'(level), 64'd0);
      repeat (40) @(negedge clk);
      send(1'b0, 8'h10, 8'h00, 4, 1'b0);
      drain(300);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
